// File: rtl/ezlogic_pkg.sv
// Shared definitions for the EzLogic output-checker slice.
// BYTE_W      : width of one stream byte
// EZ_N        : default transaction length in bytes
// EZ_EXPECTED : default golden stream, byte 0 in the most significant byte
// checker_state_t : checker FSM states
package ezlogic_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EZ_N   = 42;

  localparam logic [BYTE_W*EZ_N-1:0] EZ_EXPECTED =
    336'h30789d5692f2fe23bb2c5d9e16406653b6cb217c952998ce17b7143788d949952680b4bce4c30a96c753;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } checker_state_t;

endpackage

// File: rtl/ezlogic_gap_timer.sv
// Gap timer: counts consecutive idle cycles while a transaction is collecting.
// clk     : system clock
// rst_n   : synchronous active-low reset
// clear   : zero the counter (has priority over tick)
// tick    : one idle cycle elapsed
// expired : this tick brings the count to TIMEOUT
module ezlogic_gap_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned   GW    = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] LIMIT = GW'(TIMEOUT);
  localparam logic [GW-1:0] LAST  = GW'(TIMEOUT - 1);

  logic [GW-1:0] cnt;

  // Expiry is flagged on the tick that reaches TIMEOUT so the owner can
  // leave its waiting state on that same edge.
  assign expired = tick && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && (cnt != LIMIT)) begin
      cnt <= cnt + GW'(1);
    end
  end

endmodule

// File: rtl/ezlogic_out_checker.sv
// On-chip checker for the EzLogic core output byte stream.
// After a start pulse it collects N bytes, compares each with the golden
// stream EXPECTED (byte 0 = MSB) and reports the verdict.
// clk             : system clock
// rst_n           : synchronous active-low reset
// start           : arm pulse (honoured in IDLE and DONE)
// data_in         : stream byte
// valid_in        : byte strobe, no backpressure
// busy            : collecting
// done            : transaction finished
// pass            : all bytes matched, no timeout, no overflow
// mismatch_cnt    : number of mismatching bytes
// first_err_idx   : index of the first mismatching byte
// first_err_valid : first_err_idx is meaningful
// byte_cnt        : bytes accepted in this transaction
// timeout         : transaction ended by the gap timer
// overflow        : byte seen after completion
module ezlogic_out_checker
  import ezlogic_pkg::*;
#(
  parameter  int unsigned          N        = EZ_N,
  parameter  logic [BYTE_W*N-1:0]  EXPECTED = EZ_EXPECTED,
  parameter  int unsigned          TIMEOUT  = 64,
  localparam int unsigned          CW       = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CW-1:0]     mismatch_cnt,
  output logic [CW-1:0]     first_err_idx,
  output logic              first_err_valid,
  output logic [CW-1:0]     byte_cnt,
  output logic              timeout,
  output logic              overflow
);

  checker_state_t    state, state_next;
  logic [BYTE_W-1:0] exp_byte;
  logic              arm, accept, is_last, is_mis, gap_hit, ovf_hit;
  logic              gap_clear, gap_tick, gap_expired;

  assign busy = (state == COLLECT);
  assign done = (state == DONE);

  assign gap_clear = (state != COLLECT) || valid_in;
  assign gap_tick  = (state == COLLECT) && !valid_in;

  ezlogic_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (gap_clear),
    .tick    (gap_tick),
    .expired (gap_expired)
  );

  // Golden byte select with constant slice bounds only.
  always_comb begin
    exp_byte = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (byte_cnt == CW'(i)) begin
        exp_byte = EXPECTED[BYTE_W*(N-1-i) +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    accept     = 1'b0;
    gap_hit    = 1'b0;
    ovf_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          arm        = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (valid_in) begin
          accept = 1'b1;
          if (byte_cnt == CW'(N - 1)) state_next = DONE;
        end else if (gap_expired) begin
          gap_hit    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // start outranks a coincident byte
        if (start) begin
          arm        = 1'b1;
          state_next = COLLECT;
        end else if (valid_in) begin
          ovf_hit = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign is_mis  = accept && (data_in != exp_byte);
  assign is_last = accept && (byte_cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || arm) begin
      byte_cnt        <= '0;
      mismatch_cnt    <= '0;
      first_err_idx   <= '0;
      first_err_valid <= 1'b0;
      timeout         <= 1'b0;
      overflow        <= 1'b0;
      pass            <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + CW'(1);
        if (is_mis) begin
          mismatch_cnt <= mismatch_cnt + CW'(1);
          if (!first_err_valid) begin
            first_err_idx   <= byte_cnt;
            first_err_valid <= 1'b1;
          end
        end
        if (is_last) pass <= (mismatch_cnt == '0) && !is_mis;
      end
      if (gap_hit) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
      if (ovf_hit) begin
        overflow <= 1'b1;
        pass     <= 1'b0;
        if (byte_cnt != CW'(N)) byte_cnt <= byte_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ezlogic_out_checker.sv
// Bench for ezlogic_out_checker: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level model.
module tb_ezlogic_out_checker;
  import ezlogic_pkg::*;

  localparam int N1 = 4;
  localparam int T1 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s0 = 1'b0, v0 = 1'b0, s1 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;

  logic       busy0, done0, pass0, fev0, to0, ov0;
  logic [5:0] mc0, fei0, bc0;
  logic       busy1, done1, pass1, fev1, to1, ov1;
  logic [2:0] mc1, fei1, bc1;

  always #5 clk = ~clk;

  ezlogic_out_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(s0), .data_in(d0), .valid_in(v0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_cnt(mc0),
    .first_err_idx(fei0), .first_err_valid(fev0), .byte_cnt(bc0),
    .timeout(to0), .overflow(ov0)
  );

  ezlogic_out_checker #(
    .N(N1), .EXPECTED(32'h30789d56), .TIMEOUT(T1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .data_in(d1), .valid_in(v1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_cnt(mc1),
    .first_err_idx(fei1), .first_err_valid(fev1), .byte_cnt(bc1),
    .timeout(to1), .overflow(ov1)
  );

  // phase: 0 idle, 1 collecting, 2 finished
  typedef struct {
    int phase;
    int cnt;
    int mism;
    int fidx;
    int fv;
    int gap;
    int to;
    int ov;
    int ps;
  } mdl_t;

  mdl_t       m0, m1;
  logic [7:0] gold0 [42];
  logic [7:0] gold1 [4];
  int         checks = 0;
  int         errors = 0;
  int         cyc_n  = 0;

  function automatic mdl_t fresh(int ph);
    mdl_t r;
    r.phase = ph; r.cnt = 0; r.mism = 0; r.fidx = 0; r.fv = 0;
    r.gap = 0; r.to = 0; r.ov = 0; r.ps = 0;
    return r;
  endfunction

  function automatic mdl_t step(mdl_t m, bit rst, bit st, bit vl,
                                logic [7:0] d, logic [7:0] g, int n, int tmo);
    mdl_t r = m;
    if (rst) return fresh(0);
    case (m.phase)
      0: if (st) r = fresh(1);
      1: begin
        if (vl) begin
          if (d != g) begin
            r.mism++;
            if (r.fv == 0) begin r.fidx = r.cnt; r.fv = 1; end
          end
          r.cnt++;
          r.gap = 0;
          if (r.cnt == n) begin r.phase = 2; r.ps = (r.mism == 0); end
        end else begin
          r.gap++;
          if (r.gap == tmo) begin r.phase = 2; r.to = 1; r.ps = 0; end
        end
      end
      default: begin
        if (st) r = fresh(1);
        else if (vl) begin
          r.ov = 1; r.ps = 0;
          r.cnt = (r.cnt < n) ? r.cnt + 1 : n;
        end
      end
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cmp(string w, mdl_t m, logic b, logic dn, logic ps,
                     logic [31:0] mc, logic [31:0] fi, logic fv,
                     logic [31:0] bc, logic to, logic ov);
    chk({w, ".busy"},  32'(b),  32'(m.phase == 1));
    chk({w, ".done"},  32'(dn), 32'(m.phase == 2));
    chk({w, ".pass"},  32'(ps), 32'(m.ps));
    chk({w, ".mcnt"},  mc,      32'(m.mism));
    chk({w, ".fidx"},  fi,      32'(m.fidx));
    chk({w, ".fval"},  32'(fv), 32'(m.fv));
    chk({w, ".bcnt"},  bc,      32'(m.cnt));
    chk({w, ".tmo"},   32'(to), 32'(m.to));
    chk({w, ".ovf"},   32'(ov), 32'(m.ov));
  endtask

  task automatic cyc(bit r, bit st0, bit vl0, logic [7:0] dd0,
                     bit st1, bit vl1, logic [7:0] dd1);
    logic [7:0] g0, g1;
    rst_n = !r; s0 = st0; v0 = vl0; d0 = dd0; s1 = st1; v1 = vl1; d1 = dd1;
    g0 = (m0.cnt < 42) ? gold0[m0.cnt] : 8'h00;
    g1 = (m1.cnt < N1) ? gold1[m1.cnt] : 8'h00;
    @(posedge clk);
    cyc_n++;
    m0 = step(m0, r, st0, vl0, dd0, g0, 42, 64);
    m1 = step(m1, r, st1, vl1, dd1, g1, N1, T1);
    #1;
    cmp("dut0", m0, busy0, done0, pass0, 32'(mc0), 32'(fei0), fev0, 32'(bc0), to0, ov0);
    cmp("dut1", m1, busy1, done1, pass1, 32'(mc1), 32'(fei1), fev1, 32'(bc1), to1, ov1);
  endtask

  initial begin
    logic [335:0] e0;
    logic [31:0]  e1;
    logic [7:0]   errs [4];
    logic [7:0]   dr0, dr1;
    bit           rr, a0, a1, b0, b1;

    e0 = EZ_EXPECTED;
    for (int i = 0; i < 42; i++) begin gold0[i] = e0[335:328]; e0 = e0 << 8; end
    e1 = 32'h30789d56;
    for (int i = 0; i < 4; i++) begin gold1[i] = e1[31:24]; e1 = e1 << 8; end
    errs[0] = 8'h30; errs[1] = 8'h79; errs[2] = 8'h9d; errs[3] = 8'h00;
    m0 = fresh(0);
    m1 = fresh(0);

    // reset
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
    cyc(1, 0, 1, 8'h30, 0, 1, 8'h30);
    chk("rst.busy0", 32'(busy0), 32'd0);
    chk("rst.bcnt1", 32'(bc1), 32'd0);

    // dut0: full golden pass with a stray start at byte 2; dut1: two errors
    cyc(0, 1, 0, 8'h00, 1, 0, 8'h00);
    for (int i = 0; i < 42; i++)
      cyc(0, i == 2, 1, gold0[i], 0, i < 4, (i < 4) ? errs[i] : 8'h00);
    chk("full.done0", 32'(done0), 32'd1);
    chk("full.pass0", 32'(pass0), 32'd1);
    chk("full.bcnt0", 32'(bc0), 32'd42);
    chk("err.mcnt1",  32'(mc1), 32'd2);
    chk("err.fidx1",  32'(fei1), 32'd1);
    chk("err.pass1",  32'(pass1), 32'd0);

    // overflow, then re-arm with a coincident byte
    cyc(0, 0, 1, 8'hAA, 0, 0, 8'h00);
    chk("ovf.flag0", 32'(ov0), 32'd1);
    chk("ovf.pass0", 32'(pass0), 32'd0);
    cyc(0, 1, 1, 8'hAA, 0, 0, 8'h00);
    chk("rearm.busy0", 32'(busy0), 32'd1);
    chk("rearm.ovf0",  32'(ov0), 32'd0);
    chk("rearm.bcnt0", 32'(bc0), 32'd0);

    // dut1: bubbles then timeout
    cyc(0, 0, 0, 8'h00, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 1, 8'h30);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 1, 8'h78);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("tmo.early1", 32'(done1), 32'd0);
    cyc(0, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("tmo.done1", 32'(done1), 32'd1);
    chk("tmo.flag1", 32'(to1), 32'd1);
    chk("tmo.bcnt1", 32'(bc1), 32'd2);

    // dut1: reset mid-transaction, then bytes without start
    cyc(0, 0, 0, 8'h00, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00, 0, 1, 8'h30);
    cyc(0, 0, 0, 8'h00, 0, 1, 8'h78);
    cyc(1, 0, 0, 8'h00, 0, 0, 8'h00);
    chk("mrst.busy1", 32'(busy1), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 0, 1, gold1[i]);
    chk("mrst.bcnt1", 32'(bc1), 32'd0);

    // random traffic, with a long silence window to expire dut0's timer
    for (int k = 0; k < 500; k++) begin
      rr = ($urandom_range(0, 249) == 0);
      a0 = ($urandom_range(0, 31) == 0) || (k == 199);
      a1 = ($urandom_range(0, 15) == 0);
      b0 = ($urandom_range(0, 3) != 0) && !(k >= 200 && k < 280);
      b1 = ($urandom_range(0, 4) != 0);
      if (k >= 200 && k < 280) a0 = 1'b0;
      dr0 = ($urandom_range(0, 9) == 0) ? 8'($urandom)
          : ((m0.cnt < 42) ? gold0[m0.cnt] : 8'($urandom));
      dr1 = ($urandom_range(0, 5) == 0) ? 8'($urandom)
          : ((m1.cnt < N1) ? gold1[m1.cnt] : 8'($urandom));
      cyc(rr, a0, b0, dr0, a1, b1, dr1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
